// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 pipeline constants, E register layout and forwarding helper

package y86_pkg;

   // Instruction codes
   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   // Register IDs with special meaning
   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] RRSP  = 4'h4;

   // Pipeline status codes
   localparam logic [1:0] SAOK = 2'b00;
   localparam logic [1:0] SHLT = 2'b01;
   localparam logic [1:0] SADR = 2'b10;
   localparam logic [1:0] SINS = 2'b11;

   // Contents of the E pipeline register
   typedef struct packed {
      logic [1:0]  stat;
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [63:0] val_c;
      logic [63:0] val_a;
      logic [63:0] val_b;
      logic [3:0]  dst_e;
      logic [3:0]  dst_m;
      logic [3:0]  src_a;
      logic [3:0]  src_b;
   } e_reg_t;

   // The nop bubble injected into E on reset or on request
   localparam e_reg_t E_BUBBLE = '{
      stat:  SAOK,
      icode: INOP,
      ifun:  4'h0,
      val_c: 64'h0,
      val_a: 64'h0,
      val_b: 64'h0,
      dst_e: RNONE,
      dst_m: RNONE,
      src_a: RNONE,
      src_b: RNONE
   };

   // Forwarding priority: youngest producer first, memory load ahead of ALU
   // result within M, load ahead of ALU result within W. An RNONE source
   // never forwards; because src != RNONE is checked first, a producer whose
   // dst is RNONE can never match either.
   function automatic logic [63:0] fwd_select(
      input logic [3:0]  src,
      input logic [3:0]  e_dst_e,
      input logic [63:0] e_val_e,
      input logic [3:0]  m_dst_m,
      input logic [63:0] m_val_m,
      input logic [3:0]  m_dst_e,
      input logic [63:0] m_val_e,
      input logic [3:0]  w_dst_m,
      input logic [63:0] w_val_m,
      input logic [3:0]  w_dst_e,
      input logic [63:0] w_val_e,
      input logic [63:0] rf_val
   );
      logic [63:0] r;
      r = rf_val;
      if (src != RNONE) begin
         if (e_dst_e == src)      r = e_val_e;
         else if (m_dst_m == src) r = m_val_m;
         else if (m_dst_e == src) r = m_val_e;
         else if (w_dst_m == src) r = w_val_m;
         else if (w_dst_e == src) r = w_val_e;
      end
      return r;
   endfunction

endpackage

// File: rtl/y86_regfile.sv
// rtl/y86_regfile.sv - 15 x 64-bit register file, two async reads, two writes with M priority

module y86_regfile
   import y86_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  rd_addr_a,
   output logic [63:0] rd_data_a,
   input  logic [3:0]  rd_addr_b,
   output logic [63:0] rd_data_b,
   input  logic [3:0]  wr_addr_e,
   input  logic [63:0] wr_data_e,
   input  logic [3:0]  wr_addr_m,
   input  logic [63:0] wr_data_m
);

   localparam int NREGS = 15;

   logic [63:0] regs_q [NREGS];
   logic [63:0] regs_d [NREGS];

   // Next register contents: E write first, M write overrides it so popq %rsp
   // leaves the popped value in %rsp. Address RNONE matches no entry.
   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         regs_d[i] = regs_q[i];
         if (wr_addr_e != RNONE && wr_addr_e == 4'(i)) regs_d[i] = wr_data_e;
         if (wr_addr_m != RNONE && wr_addr_m == 4'(i)) regs_d[i] = wr_data_m;
      end
   end

   // Register storage; reset clears everything and drops any write at that edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= 64'h0;
      end else begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      end
   end

   // Combinational read ports; RNONE reads as zero
   always_comb begin
      rd_data_a = 64'h0;
      rd_data_b = 64'h0;
      for (int i = 0; i < NREGS; i++) begin
         if (rd_addr_a == 4'(i)) rd_data_a = regs_q[i];
         if (rd_addr_b == 4'(i)) rd_data_b = regs_q[i];
      end
   end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - Y86-64 decode/writeback stage with forwarding and E pipeline register

module decode_stage
   import y86_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  D_stat,
   input  logic [3:0]  D_icode,
   input  logic [3:0]  D_ifun,
   input  logic [3:0]  D_rA,
   input  logic [3:0]  D_rB,
   input  logic [63:0] D_valC,
   input  logic [63:0] D_valP,
   input  logic        E_bubble,
   input  logic [3:0]  e_dstE,
   input  logic [63:0] e_valE,
   input  logic [3:0]  M_dstE,
   input  logic [63:0] M_valE,
   input  logic [3:0]  M_dstM,
   input  logic [63:0] m_valM,
   input  logic [3:0]  W_dstE,
   input  logic [63:0] W_valE,
   input  logic [3:0]  W_dstM,
   input  logic [63:0] W_valM,
   output logic [3:0]  d_srcA,
   output logic [3:0]  d_srcB,
   output logic [1:0]  E_stat,
   output logic [3:0]  E_icode,
   output logic [3:0]  E_ifun,
   output logic [63:0] E_valC,
   output logic [63:0] E_valA,
   output logic [63:0] E_valB,
   output logic [3:0]  E_dstE,
   output logic [3:0]  E_dstM,
   output logic [3:0]  E_srcA,
   output logic [3:0]  E_srcB
);

   logic [3:0]  src_a;
   logic [3:0]  src_b;
   logic [3:0]  dst_e;
   logic [3:0]  dst_m;
   logic [63:0] rf_a;
   logic [63:0] rf_b;
   logic [63:0] val_a;
   logic [63:0] val_b;
   e_reg_t      e_reg_d;
   e_reg_t      e_reg_q;

   // Register-file reads on the selected sources, writeback from W
   y86_regfile u_regfile (
      .clk       (clk),
      .rst       (rst),
      .rd_addr_a (src_a),
      .rd_data_a (rf_a),
      .rd_addr_b (src_b),
      .rd_data_b (rf_b),
      .wr_addr_e (W_dstE),
      .wr_data_e (W_valE),
      .wr_addr_m (W_dstM),
      .wr_data_m (W_valM)
   );

   // Source/destination register selection per instruction class; halt, nop
   // and undefined icodes leave everything at RNONE
   always_comb begin
      src_a = RNONE;
      src_b = RNONE;
      dst_e = RNONE;
      dst_m = RNONE;
      case (D_icode)
         IRRMOVQ: begin
            src_a = D_rA;
            dst_e = D_rB;
         end
         IIRMOVQ: begin
            dst_e = D_rB;
         end
         IRMMOVQ: begin
            src_a = D_rA;
            src_b = D_rB;
         end
         IMRMOVQ: begin
            src_b = D_rB;
            dst_m = D_rA;
         end
         IOPQ: begin
            src_a = D_rA;
            src_b = D_rB;
            dst_e = D_rB;
         end
         ICALL: begin
            src_b = RRSP;
            dst_e = RRSP;
         end
         IRET: begin
            src_a = RRSP;
            src_b = RRSP;
            dst_e = RRSP;
         end
         IPUSHQ: begin
            src_a = D_rA;
            src_b = RRSP;
            dst_e = RRSP;
         end
         IPOPQ: begin
            src_a = RRSP;
            src_b = RRSP;
            dst_e = RRSP;
            dst_m = D_rA;
         end
         default: ;
      endcase
   end

   assign d_srcA = src_a;
   assign d_srcB = src_b;

   // Operand values: call and jXX carry the return/fall-through PC in valA,
   // everything else takes the forwarded or register-file value
   always_comb begin
      val_b = fwd_select(src_b, e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
                         W_dstM, W_valM, W_dstE, W_valE, rf_b);
      if (D_icode == ICALL || D_icode == IJXX) begin
         val_a = D_valP;
      end else begin
         val_a = fwd_select(src_a, e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
                            W_dstM, W_valM, W_dstE, W_valE, rf_a);
      end
   end

   // Next E register contents: either the decoded instruction or a nop bubble
   always_comb begin
      e_reg_d       = E_BUBBLE;
      if (!E_bubble) begin
         e_reg_d.stat  = D_stat;
         e_reg_d.icode = D_icode;
         e_reg_d.ifun  = D_ifun;
         e_reg_d.val_c = D_valC;
         e_reg_d.val_a = val_a;
         e_reg_d.val_b = val_b;
         e_reg_d.dst_e = dst_e;
         e_reg_d.dst_m = dst_m;
         e_reg_d.src_a = src_a;
         e_reg_d.src_b = src_b;
      end
   end

   // E pipeline register; execute never stalls so it loads every edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) e_reg_q <= E_BUBBLE;
      else     e_reg_q <= e_reg_d;
   end

   assign E_stat  = e_reg_q.stat;
   assign E_icode = e_reg_q.icode;
   assign E_ifun  = e_reg_q.ifun;
   assign E_valC  = e_reg_q.val_c;
   assign E_valA  = e_reg_q.val_a;
   assign E_valB  = e_reg_q.val_b;
   assign E_dstE  = e_reg_q.dst_e;
   assign E_dstM  = e_reg_q.dst_m;
   assign E_srcA  = e_reg_q.src_a;
   assign E_srcB  = e_reg_q.src_b;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage

module tb_decode_stage;

   logic        clk;
   logic        rst;
   logic [1:0]  D_stat;
   logic [3:0]  D_icode;
   logic [3:0]  D_ifun;
   logic [3:0]  D_rA;
   logic [3:0]  D_rB;
   logic [63:0] D_valC;
   logic [63:0] D_valP;
   logic        E_bubble;
   logic [3:0]  e_dstE;
   logic [63:0] e_valE;
   logic [3:0]  M_dstE;
   logic [63:0] M_valE;
   logic [3:0]  M_dstM;
   logic [63:0] m_valM;
   logic [3:0]  W_dstE;
   logic [63:0] W_valE;
   logic [3:0]  W_dstM;
   logic [63:0] W_valM;
   logic [3:0]  d_srcA;
   logic [3:0]  d_srcB;
   logic [1:0]  E_stat;
   logic [3:0]  E_icode;
   logic [3:0]  E_ifun;
   logic [63:0] E_valC;
   logic [63:0] E_valA;
   logic [63:0] E_valB;
   logic [3:0]  E_dstE;
   logic [3:0]  E_dstM;
   logic [3:0]  E_srcA;
   logic [3:0]  E_srcB;

   int n_checks = 0;
   int n_pass   = 0;

   decode_stage dut (
      .clk      (clk),
      .rst      (rst),
      .D_stat   (D_stat),
      .D_icode  (D_icode),
      .D_ifun   (D_ifun),
      .D_rA     (D_rA),
      .D_rB     (D_rB),
      .D_valC   (D_valC),
      .D_valP   (D_valP),
      .E_bubble (E_bubble),
      .e_dstE   (e_dstE),
      .e_valE   (e_valE),
      .M_dstE   (M_dstE),
      .M_valE   (M_valE),
      .M_dstM   (M_dstM),
      .m_valM   (m_valM),
      .W_dstE   (W_dstE),
      .W_valE   (W_valE),
      .W_dstM   (W_dstM),
      .W_valM   (W_valM),
      .d_srcA   (d_srcA),
      .d_srcB   (d_srcB),
      .E_stat   (E_stat),
      .E_icode  (E_icode),
      .E_ifun   (E_ifun),
      .E_valC   (E_valC),
      .E_valA   (E_valA),
      .E_valB   (E_valB),
      .E_dstE   (E_dstE),
      .E_dstM   (E_dstM),
      .E_srcA   (E_srcA),
      .E_srcB   (E_srcB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_taps();
      e_dstE = 4'hF; e_valE = 64'h0;
      M_dstE = 4'hF; M_valE = 64'h0;
      M_dstM = 4'hF; m_valM = 64'h0;
      W_dstE = 4'hF; W_valE = 64'h0;
      W_dstM = 4'hF; W_valM = 64'h0;
   endtask

   task automatic set_d(input logic [3:0] icode, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [63:0] valc, input logic [63:0] valp);
      D_stat  = 2'b00;
      D_icode = icode;
      D_ifun  = 4'h0;
      D_rA    = ra;
      D_rB    = rb;
      D_valC  = valc;
      D_valP  = valp;
   endtask

   initial begin
      rst      = 1'b0;
      E_bubble = 1'b0;
      clear_taps();
      set_d(4'h3, 4'hF, 4'h6, 64'h1234, 64'h0);
      tick();
      tick();

      // Asynchronous reset mid-cycle with a writeback pending at the reset edge
      #3;
      rst = 1'b1;
      #1;
      check("rst_icode", E_icode, 64'h1);
      check("rst_dstE", E_dstE, 64'hF);
      check("rst_valC", E_valC, 64'h0);
      W_dstE = 4'h3; W_valE = 64'h99;
      tick();
      check("rst_hold_icode", E_icode, 64'h1);
      #3;
      rst = 1'b0;
      clear_taps();
      set_d(4'h6, 4'h3, 4'h3, 64'h0, 64'h0);
      #1;
      check("opq_d_srcA", d_srcA, 64'h3);
      check("opq_d_srcB", d_srcB, 64'h3);
      tick();
      check("rst_r3_valA", E_valA, 64'h0);
      check("rst_r3_valB", E_valB, 64'h0);

      // Writeback of r3, then a plain register-file read
      W_dstE = 4'h3; W_valE = 64'h55;
      tick();
      clear_taps();
      tick();
      check("wb_valA", E_valA, 64'h55);
      check("wb_valB", E_valB, 64'h55);
      check("wb_dstE", E_dstE, 64'h3);
      check("wb_icode", E_icode, 64'h6);

      // Forwarding priority on srcA = 2 (rrmovq %r2, %r5)
      set_d(4'h2, 4'h2, 4'h5, 64'h0, 64'h0);
      e_dstE = 4'h2; e_valE = 64'h11;
      M_dstE = 4'h2; M_valE = 64'h22;
      W_dstE = 4'h2; W_valE = 64'h33;
      tick();
      check("fwd_e", E_valA, 64'h11);
      check("fwd_rr_dstE", E_dstE, 64'h5);
      check("fwd_rr_srcB", E_srcB, 64'hF);
      e_dstE = 4'hF;
      tick();
      check("fwd_M_E", E_valA, 64'h22);
      M_dstM = 4'h2; m_valM = 64'h44;
      tick();
      check("fwd_M_M", E_valA, 64'h44);
      M_dstM = 4'hF; M_dstE = 4'hF;
      tick();
      check("fwd_W_E", E_valA, 64'h33);
      clear_taps();
      tick();
      check("fwd_rf_r2", E_valA, 64'h33);

      // A producer tagged RNONE must not forward to an RNONE source
      set_d(4'h3, 4'hF, 4'h7, 64'h8, 64'h0);
      e_dstE = 4'hF; e_valE = 64'h77;
      tick();
      check("fwd_none_valA", E_valA, 64'h0);
      clear_taps();

      // call: valA is valP, %rsp is source and destination
      set_d(4'h8, 4'hF, 4'hF, 64'h400, 64'h100);
      tick();
      check("call_valA", E_valA, 64'h100);
      check("call_srcB", E_srcB, 64'h4);
      check("call_dstE", E_dstE, 64'h4);
      check("call_valB", E_valB, 64'h0);
      check("call_srcA", E_srcA, 64'hF);
      set_d(4'h7, 4'hF, 4'hF, 64'h500, 64'h200);
      tick();
      check("jxx_valA", E_valA, 64'h200);
      check("jxx_dstE", E_dstE, 64'hF);

      // popq %rsp writeback: M port wins over E port
      W_dstE = 4'h4; W_valE = 64'h10;
      W_dstM = 4'h4; W_valM = 64'h20;
      tick();
      clear_taps();
      set_d(4'hB, 4'h7, 4'hF, 64'h0, 64'h0);
      tick();
      check("pop_rsp_valA", E_valA, 64'h20);
      check("pop_rsp_valB", E_valB, 64'h20);
      check("pop_dstM", E_dstM, 64'h7);
      check("pop_dstE", E_dstE, 64'h4);

      // Undefined icode selects no registers
      set_d(4'hC, 4'h1, 4'h2, 64'h0, 64'h0);
      #1;
      check("bad_d_srcA", d_srcA, 64'hF);
      check("bad_d_srcB", d_srcB, 64'hF);

      // Bubble over irmovq, then irmovq loads normally
      set_d(4'h3, 4'hF, 4'h6, 64'hDEAD, 64'h0);
      D_stat = 2'b10;
      E_bubble = 1'b1;
      tick();
      check("bub_icode", E_icode, 64'h1);
      check("bub_valC", E_valC, 64'h0);
      check("bub_dstE", E_dstE, 64'hF);
      check("bub_stat", E_stat, 64'h0);
      E_bubble = 1'b0;
      tick();
      check("irm_icode", E_icode, 64'h3);
      check("irm_dstE", E_dstE, 64'h6);
      check("irm_valC", E_valC, 64'hDEAD);
      check("irm_stat", E_stat, 64'h2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
